// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: the hazard inputs sampled from the pipeline
// registers and the enables, squashes and status the controller returns.
// The controller connects through the slave modport. The pipeline side,
// or a testbench standing in for it, connects through the master modport.
interface pipe_hazard_ctrl_if;
  // Hazard inputs taken from the pipeline registers
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  idex_rd;
  logic        idex_MemRead;
  logic        exmem_branch;
  logic        exmem_zero;
  logic        dmem_req;
  logic        dmem_ready;

  // Pipeline control returned by the controller
  logic        pc_write;
  logic        ifid_write;
  logic        pipe_en;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        pc_src;

  // Status
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic        mem_timeout;

  modport slave (
    input  id_rs1, id_rs2, idex_rd, idex_MemRead,
           exmem_branch, exmem_zero, dmem_req, dmem_ready,
    output pc_write, ifid_write, pipe_en, idex_bubble,
           ifid_flush, idex_flush, exmem_flush, pc_src,
           state, stall_cnt, mem_timeout
  );

  modport master (
    output id_rs1, id_rs2, idex_rd, idex_MemRead,
           exmem_branch, exmem_zero, dmem_req, dmem_ready,
    input  pc_write, ifid_write, pipe_en, idex_bubble,
           ifid_flush, idex_flush, exmem_flush, pc_src,
           state, stall_cnt, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline.
// It handles three hazards:
//  - Load-use: stall the front end for one cycle and insert a bubble.
//  - Taken branch: squash IF/ID, ID/EX and EX/MEM, redirect the PC, and
//    bubble ID/EX on the following cycle.
//  - Slow data memory: freeze the whole pipeline until dmem_ready. The
//    freeze is released after TIMEOUT wait cycles. A forced release sets
//    the sticky mem_timeout flag.
// Pending memory access beats a taken branch, and a taken branch beats a
// load-use.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255  // 1..255 MEM_WAIT cycles
) (
  input  logic                   clk,
  input  logic                   reset,
  pipe_hazard_ctrl_if.slave      bus
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_FLUSH    = 2'b10,
    ST_MEM_WAIT = 2'b11
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_cnt_nxt;
  logic [15:0] r_stall_cnt;
  logic        r_mem_timeout;
  logic        w_set_timeout;

  // Hazard terms
  logic w_load_use;
  logic w_br_taken;
  logic w_mem_busy;

  // Per-cycle actions chosen by the FSM
  logic w_freeze;     // hold PC, IF/ID and the back-end registers
  logic w_squash;     // taken branch: redirect the PC and squash three stages
  logic w_lu_stall;   // hold PC and IF/ID, bubble ID/EX
  logic w_fl_bubble;  // second half of a branch flush

  // Control outputs
  logic w_pc_write;
  logic w_ifid_write;
  logic w_pipe_en;
  logic w_idex_bubble;
  logic w_flush;

  // Register 0 is hard-wired, so a load into x0 never causes a load-use stall.
  assign w_load_use = bus.idex_MemRead && (bus.idex_rd != 5'd0) &&
                      ((bus.idex_rd == bus.id_rs1) || (bus.idex_rd == bus.id_rs2));
  assign w_br_taken = bus.exmem_branch && bus.exmem_zero;
  assign w_mem_busy = bus.dmem_req && !bus.dmem_ready;

  // Next-state and action selection
  always_comb begin
    // NOTE: every variable gets a default before any branch; otherwise a
    // path that skips an assignment infers a latch.
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_set_timeout  = 1'b0;
    w_freeze       = 1'b0;
    w_squash       = 1'b0;
    w_lu_stall     = 1'b0;
    w_fl_bubble    = 1'b0;

    // NOTE: the actions are gated by reset, not only by the state register.
    // The state register already reads RUN during reset, but a RUN-state
    // hazard would still drive a stall without this gate.
    if (!reset) begin
      unique case (r_state)
        ST_RUN, ST_LU_STALL: begin
          if (w_mem_busy) begin
            w_freeze       = 1'b1;
            w_state_nxt    = ST_MEM_WAIT;
            w_wait_cnt_nxt = 8'd1;
          end else if (w_br_taken) begin
            w_squash    = 1'b1;
            w_state_nxt = ST_FLUSH;
          end else if ((r_state == ST_RUN) && w_load_use) begin
            // A load-use stall that has just been taken is not evaluated again.
            w_lu_stall  = 1'b1;
            w_state_nxt = ST_LU_STALL;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end

        ST_FLUSH: begin
          // Branches and load-uses here come from squashed instructions.
          if (w_mem_busy) begin
            w_freeze       = 1'b1;
            w_state_nxt    = ST_MEM_WAIT;
            w_wait_cnt_nxt = 8'd1;
          end else begin
            w_fl_bubble = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end

        ST_MEM_WAIT: begin
          if (bus.dmem_ready) begin
            w_state_nxt    = ST_RUN;
            w_wait_cnt_nxt = 8'd0;
          end else if (r_wait_cnt == LP_TIMEOUT) begin
            // Give up on the memory so that the pipeline cannot deadlock.
            w_state_nxt    = ST_RUN;
            w_wait_cnt_nxt = 8'd0;
            w_set_timeout  = 1'b1;
          end else begin
            w_freeze       = 1'b1;
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
          end
        end

        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Map the selected action onto the pipeline enables
  always_comb begin
    w_pc_write    = !(w_freeze || w_lu_stall);
    w_ifid_write  = !(w_freeze || w_lu_stall);
    w_pipe_en     = !w_freeze;
    w_idex_bubble = w_lu_stall || w_fl_bubble;
    w_flush       = w_squash;
  end

  // FSM state and wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples its value from before the clock edge.
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Saturating count of the cycles in which the PC is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
    end else if (!w_pc_write && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Sticky forced-release flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_timeout <= 1'b0;
    end else if (w_set_timeout) begin
      r_mem_timeout <= 1'b1;
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.ifid_write  = w_ifid_write;
  assign bus.pipe_en     = w_pipe_en;
  assign bus.idex_bubble = w_idex_bubble;
  assign bus.ifid_flush  = w_flush;
  assign bus.idex_flush  = w_flush;
  assign bus.exmem_flush = w_flush;
  assign bus.pc_src      = w_squash;
  assign bus.state       = r_state;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. The driver applies one set of
// inputs per cycle, 1 ns after the rising edge. A reference model then
// pushes the expected outputs for that cycle. The monitor pops and
// compares them on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 4;

  typedef struct packed {
    logic [7:0]  ctrl;  // pc_write,ifid_write,pipe_en,bubble,ifid_fl,idex_fl,exmem_fl,pc_src
    logic [1:0]  st;
    logic [15:0] stall;
    logic        tmo;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pipe_hazard_ctrl_if bus();

  pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model. It tracks the outstanding obligations, not FSM states:
  // the cycles spent waiting on memory, a pending post-branch bubble, and a
  // load-use stall that has just been taken.
  int   m_wait_cycles = 0;
  bit   m_bubble_owed = 1'b0;
  bit   m_just_stalled = 1'b0;
  bit   m_tmo = 1'b0;
  int   m_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input bit mr, input bit br, input bit zr,
                            input bit req, input bit rdy);
    exp_t e;
    bit pcw, ifw, pen, bub, fl, psrc, busy, brt, lu;
    pcw = 1; ifw = 1; pen = 1; bub = 0; fl = 0; psrc = 0;
    if (rst) begin
      m_wait_cycles = 0; m_bubble_owed = 0; m_just_stalled = 0; m_tmo = 0; m_stall = 0;
      e.ctrl = 8'b1110_0000; e.st = 2'd0; e.stall = 16'd0; e.tmo = 1'b0;
      q.push_back(e);
      return;
    end
    busy = req && !rdy;
    brt  = br && zr;
    lu   = mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
    e.st    = (m_wait_cycles > 0) ? 2'd3 : m_bubble_owed ? 2'd2 : m_just_stalled ? 2'd1 : 2'd0;
    e.stall = 16'(m_stall);
    e.tmo   = m_tmo;
    if (m_wait_cycles > 0) begin
      if (rdy) m_wait_cycles = 0;
      else if (m_wait_cycles == int'(TO)) begin m_wait_cycles = 0; m_tmo = 1; end
      else begin pcw = 0; ifw = 0; pen = 0; m_wait_cycles++; end
    end else if (busy) begin
      pcw = 0; ifw = 0; pen = 0;
      m_wait_cycles = 1; m_bubble_owed = 0; m_just_stalled = 0;
    end else if (m_bubble_owed) begin
      bub = 1; m_bubble_owed = 0;
    end else if (brt) begin
      psrc = 1; fl = 1; m_bubble_owed = 1; m_just_stalled = 0;
    end else if (lu && !m_just_stalled) begin
      pcw = 0; ifw = 0; bub = 1; m_just_stalled = 1;
    end else begin
      m_just_stalled = 0;
    end
    e.ctrl = {pcw, ifw, pen, bub, fl, fl, fl, psrc};
    q.push_back(e);
    if (!pcw && m_stall < 65535) m_stall++;
  endtask

  // One cycle of stimulus. When async_rst is set, reset rises between edges.
  task automatic drive(input bit rst, input bit async_rst, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input bit mr,
                       input bit br, input bit zr, input bit req, input bit rdy);
    @(posedge clk);
    #1;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.idex_rd = rd; bus.idex_MemRead = mr;
    bus.exmem_branch = br; bus.exmem_zero = zr; bus.dmem_req = req; bus.dmem_ready = rdy;
    if (async_rst) begin
      reset = 1'b0;
      #2;
      reset = 1'b1;
      model_step(1'b1, rs1, rs2, rd, mr, br, zr, req, rdy);
    end else begin
      reset = rst;
      model_step(rst, rs1, rs2, rd, mr, br, zr, req, rdy);
    end
  endtask

  task automatic idle();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares one expected record per falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ctrl", 32'({bus.pc_write, bus.ifid_write, bus.pipe_en, bus.idex_bubble,
                           bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.pc_src}), 32'(e.ctrl));
        check("state", 32'(bus.state), 32'(e.st));
        check("stall_cnt", 32'(bus.stall_cnt), 32'(e.stall));
        check("mem_timeout", 32'(bus.mem_timeout), 32'(e.tmo));
      end
    end
  end

  // Stimulus
  initial begin
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.idex_rd = '0; bus.idex_MemRead = 0;
    bus.exmem_branch = 0; bus.exmem_zero = 0; bus.dmem_req = 0; bus.dmem_ready = 0;

    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    idle();

    // Load-use on rs2, then the LU_STALL cycle, then back to RUN
    drive(0, 0, 5'd0, 5'd5, 5'd5, 1, 0, 0, 0, 0);
    drive(0, 0, 5'd0, 5'd5, 5'd5, 1, 0, 0, 0, 0);
    idle();
    // Load into x0 never stalls
    drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);

    // Taken branch, then the bubble cycle, then RUN
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0);
    idle();

    // Memory is busy for three cycles and releases on the fourth
    repeat (3) drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    idle();

    // Forced release after TIMEOUT cycles; the flag stays set
    repeat (5) drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    idle();
    idle();

    // Branch, load-use and a busy memory in the same cycle: the freeze wins
    drive(0, 0, 5'd3, 5'd0, 5'd3, 1, 1, 1, 1, 0);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    // Branch and load-use together: only the branch is taken
    drive(0, 0, 5'd7, 5'd0, 5'd7, 1, 1, 1, 0, 0);
    idle();
    idle();

    // Reset pulse between edges in the middle of MEM_WAIT
    repeat (2) drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    drive(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    idle();
    // Reset pulse in the middle of FLUSH
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0);
    drive(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(0, ($urandom_range(0, 199) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end
    idle();

    // Wait for the monitor to drain the queue, with a fixed cycle bound
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
